multdiv: RTL and testbench

MULTDIV -- requirements
Module: multdiv

---
 rtl/multdiv_pkg.sv | 24 ++
 rtl/multdiv_if.sv | 28 ++
 rtl/multdiv_counter.sv | 33 +++
 rtl/multdiv.sv | 156 +++++++++++++++
 tb/tb_multdiv.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_pkg
//  Brief    : Shared state/op encodings and constants for the multdiv slice.
//  Revision : 1.0
// ============================================================================
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

    localparam int          ITER_DEFAULT = 32;
    localparam logic [31:0] INT_MIN      = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/multdiv_if.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_if
//  Brief    : Operand/command and result bus of the multiply/divide unit.
//  Revision : 1.0
// ============================================================================
interface multdiv_if;

    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );

endinterface
`default_nettype wire

// File: rtl/multdiv_counter.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_counter
//  Brief    : 6-bit iteration counter; o_terminal marks the step reaching ITER.
//  Revision : 1.0
// ============================================================================
module multdiv_counter #(
    parameter int ITER = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_clear,
    input  wire logic i_en,
    output logic      o_terminal
);

    logic [5:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 6'd1;
        end
    end

    // High on the enabled step that brings the count to ITER.
    assign o_terminal = i_en && (r_count == 6'(ITER - 1));

endmodule
`default_nettype wire

// File: rtl/multdiv.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv
//  Brief    : Iterative signed multiply (radix-2 Booth) / divide (restoring).
//  Revision : 1.0
// ============================================================================
module multdiv
    import multdiv_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  wire logic clock,
    input  wire logic reset,
    multdiv_if.slave  bus
);

    state_e      r_state;
    op_e         r_op;
    logic [63:0] r_work;
    logic        r_qm1;
    logic [31:0] r_opb;
    logic        r_neg;
    logic        r_divz;
    logic        r_ovf;
    logic [31:0] r_result;
    logic        r_exception;
    logic        r_rdy;

    logic        w_accept;
    op_e         w_op_new;
    logic        w_iter_en;
    logic        w_last;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_shift_hi;
    logic [32:0] w_add_a;
    logic [32:0] w_add_b;
    logic        w_sub;
    logic [32:0] w_sum;
    logic [63:0] w_next;
    logic [31:0] w_quot;
    logic        w_mul_ovf;

    assign w_accept  = bus.ctrl_MULT | bus.ctrl_DIV;
    assign w_op_new  = bus.ctrl_MULT ? OP_MULT : OP_DIV;
    assign w_iter_en = (r_state == RUN) && !w_accept;
    assign w_abs_a   = bus.data_operandA[31] ? (32'd0 - bus.data_operandA) : bus.data_operandA;
    assign w_abs_b   = bus.data_operandB[31] ? (32'd0 - bus.data_operandB) : bus.data_operandB;

    multdiv_counter #(.ITER(ITER)) u_counter (
        .clk        (clock),
        .rst_n      (reset),
        .i_clear    (w_accept),
        .i_en       (w_iter_en),
        .o_terminal (w_last)
    );

    // Remainder shifted left one bit; magnitudes keep it within 32 bits.
    assign w_shift_hi = {r_work[62:32], r_work[31]};

    always_comb begin
        w_add_a = '0;
        w_add_b = '0;
        w_sub   = 1'b0;
        if (r_op == OP_MULT) begin
            w_add_a = {r_work[63], r_work[63:32]};
            case ({r_work[0], r_qm1})
                2'b01:   w_add_b = {r_opb[31], r_opb};
                2'b10: begin
                    w_add_b = {r_opb[31], r_opb};
                    w_sub   = 1'b1;
                end
                default: w_add_b = '0;
            endcase
        end else begin
            w_add_a = {1'b0, w_shift_hi};
            w_add_b = {1'b0, r_opb};
            w_sub   = 1'b1;
        end
    end

    assign w_sum = w_add_a + (w_sub ? ~w_add_b : w_add_b) + {32'd0, w_sub};

    always_comb begin
        w_next = r_work;
        if (r_op == OP_MULT) begin
            w_next = {w_sum, r_work[31:1]};
        end else if (!w_sum[32]) begin
            w_next = {w_sum[31:0], r_work[30:0], 1'b1};
        end else begin
            w_next = {w_shift_hi, r_work[30:0], 1'b0};
        end
    end

    assign w_quot    = r_neg ? (32'd0 - w_next[31:0]) : w_next[31:0];
    assign w_mul_ovf = !((&w_next[63:31]) || (~|w_next[63:31]));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_op        <= OP_MULT;
            r_work      <= '0;
            r_qm1       <= 1'b0;
            r_opb       <= '0;
            r_neg       <= 1'b0;
            r_divz      <= 1'b0;
            r_ovf       <= 1'b0;
            r_result    <= '0;
            r_exception <= 1'b0;
            r_rdy       <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (w_accept) begin
                r_state <= RUN;
                r_op    <= w_op_new;
                r_qm1   <= 1'b0;
                r_neg   <= bus.data_operandA[31] ^ bus.data_operandB[31];
                r_divz  <= (bus.data_operandB == 32'd0);
                r_ovf   <= (bus.data_operandA == INT_MIN) && (bus.data_operandB == 32'hFFFF_FFFF);
                if (w_op_new == OP_MULT) begin
                    r_work <= {32'd0, bus.data_operandB};
                    r_opb  <= bus.data_operandA;
                end else begin
                    r_work <= {32'd0, w_abs_a};
                    r_opb  <= w_abs_b;
                end
            end else begin
                case (r_state)
                    RUN: begin
                        r_work <= w_next;
                        r_qm1  <= r_work[0];
                        if (w_last) begin
                            r_state <= DONE;
                            r_rdy   <= 1'b1;
                            if (r_op == OP_MULT) begin
                                r_result    <= w_next[31:0];
                                r_exception <= w_mul_ovf;
                            end else begin
                                r_result    <= r_divz ? 32'd0 : w_quot;
                                r_exception <= r_divz | r_ovf;
                            end
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exception;
    assign bus.data_resultRDY = r_rdy;

endmodule
`default_nettype wire

// File: tb/tb_multdiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multdiv
//  Brief    : Directed self-checking bench for the multdiv unit.
//  Revision : 1.0
// ============================================================================
module tb_multdiv;

    logic clock = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clock = ~clock;

    multdiv_if bus ();

    multdiv #(.ITER(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Drives a command for one accept edge, then scrambles the operands.
    task automatic start(input logic mul, input logic div,
                         input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = mul;
        bus.ctrl_DIV      = div;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = ~a;
        bus.data_operandB = b ^ 32'h1234_5678;
    endtask

    // Samples cycles 0..n-1 after the accept edge; records strobes.
    task automatic watch(input int n, output int f, output int c,
                         output logic [31:0] r, output logic e);
        f = -1;
        c = 0;
        r = '0;
        e = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) begin
                c++;
                if (f < 0) begin
                    f = k;
                    r = bus.data_result;
                    e = bus.data_exception;
                end
            end
        end
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if (bus.data_result !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_result: got %h expected 00000000", bus.data_result);
        end
        tests_run++;
        if (bus.data_exception !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_exception: got %b expected 0", bus.data_exception);
        end
        repeat (3) @(posedge clock);
        #1;
        tests_run++;
        if (bus.data_resultRDY !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rdy: got %b expected 0", bus.data_resultRDY);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Starts straight after reset release: the first edge must accept.
    task automatic test_mult_neg();
        int f, c; logic [31:0] r; logic e;
        start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        watch(40, f, c, r, e);
        tests_run++;
        if (f !== 32) begin tests_failed++; $display("FAIL mult_neg_latency: got %0d expected 32", f); end
        tests_run++;
        if (c !== 1) begin tests_failed++; $display("FAIL mult_neg_strobes: got %0d expected 1", c); end
        tests_run++;
        if (r !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mult_neg_result: got %h expected ffffffeb", r); end
        tests_run++;
        if (e !== 1'b0) begin tests_failed++; $display("FAIL mult_neg_exception: got %b expected 0", e); end
    endtask

    task automatic test_mult_ovf();
        int f, c; logic [31:0] r; logic e;
        @(negedge clock);
        start(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        watch(40, f, c, r, e);
        tests_run++;
        if (f !== 32) begin tests_failed++; $display("FAIL mult_ovf_latency: got %0d expected 32", f); end
        tests_run++;
        if (r !== 32'd0) begin tests_failed++; $display("FAIL mult_ovf_result: got %h expected 00000000", r); end
        tests_run++;
        if (e !== 1'b1) begin tests_failed++; $display("FAIL mult_ovf_exception: got %b expected 1", e); end
    endtask

    task automatic test_div();
        int f, c; logic [31:0] r; logic e;
        @(negedge clock);
        start(1'b0, 1'b1, 32'hFFFF_FFEC, 32'd3);
        watch(40, f, c, r, e);
        tests_run++;
        if (f !== 32) begin tests_failed++; $display("FAIL div_latency: got %0d expected 32", f); end
        tests_run++;
        if (r !== 32'hFFFF_FFFA) begin tests_failed++; $display("FAIL div_neg_result: got %h expected fffffffa", r); end
        tests_run++;
        if (e !== 1'b0) begin tests_failed++; $display("FAIL div_neg_exception: got %b expected 0", e); end

        @(negedge clock);
        start(1'b0, 1'b1, 32'd5, 32'd0);
        watch(40, f, c, r, e);
        tests_run++;
        if (f !== 32) begin tests_failed++; $display("FAIL div0_latency: got %0d expected 32", f); end
        tests_run++;
        if (r !== 32'd0) begin tests_failed++; $display("FAIL div0_result: got %h expected 00000000", r); end
        tests_run++;
        if (e !== 1'b1) begin tests_failed++; $display("FAIL div0_exception: got %b expected 1", e); end

        @(negedge clock);
        start(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        watch(40, f, c, r, e);
        tests_run++;
        if (r !== 32'h8000_0000) begin tests_failed++; $display("FAIL divmin_result: got %h expected 80000000", r); end
        tests_run++;
        if (e !== 1'b1) begin tests_failed++; $display("FAIL divmin_exception: got %b expected 1", e); end
    endtask

    // Second command lands on the DONE edge of the first.
    task automatic test_back_to_back();
        int f, c; logic [31:0] r; logic e;
        @(negedge clock);
        start(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
        watch(33, f, c, r, e);
        tests_run++;
        if (f !== 32) begin tests_failed++; $display("FAIL b2b_first_latency: got %0d expected 32", f); end
        tests_run++;
        if (r !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL b2b_first_result: got %h expected fffffffd", r); end
        start(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        watch(40, f, c, r, e);
        tests_run++;
        if (f !== 32) begin tests_failed++; $display("FAIL b2b_second_latency: got %0d expected 32", f); end
        tests_run++;
        if (r !== 32'h8000_0000) begin tests_failed++; $display("FAIL b2b_second_result: got %h expected 80000000", r); end
        tests_run++;
        if (e !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_exception: got %b expected 1", e); end
        tests_run++;
        if (bus.data_result !== 32'h8000_0000) begin
            tests_failed++;
            $display("FAIL b2b_hold: got %h expected 80000000", bus.data_result);
        end
    endtask

    task automatic test_abort();
        int f, c; logic [31:0] r; logic e;
        @(negedge clock);
        start(1'b1, 1'b0, 32'd2, 32'd3);
        watch(10, f, c, r, e);
        tests_run++;
        if (c !== 0) begin tests_failed++; $display("FAIL abort_early_strobes: got %0d expected 0", c); end
        start(1'b0, 1'b1, 32'd100, 32'd7);
        watch(40, f, c, r, e);
        tests_run++;
        if (f !== 32) begin tests_failed++; $display("FAIL abort_latency: got %0d expected 32 (cycle 42)", f); end
        tests_run++;
        if (c !== 1) begin tests_failed++; $display("FAIL abort_strobes: got %0d expected 1", c); end
        tests_run++;
        if (r !== 32'd14) begin tests_failed++; $display("FAIL abort_result: got %h expected 0000000e", r); end
    endtask

    task automatic test_reset_mid();
        int f, c; logic [31:0] r; logic e;
        @(negedge clock);
        start(1'b1, 1'b0, 32'd5, 32'd7);
        watch(15, f, c, r, e);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (bus.data_result !== 32'd0) begin tests_failed++; $display("FAIL midrst_result: got %h expected 00000000", bus.data_result); end
        tests_run++;
        if (bus.data_exception !== 1'b0) begin tests_failed++; $display("FAIL midrst_exception: got %b expected 0", bus.data_exception); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        watch(45, f, c, r, e);
        tests_run++;
        if (c !== 0) begin tests_failed++; $display("FAIL midrst_strobes: got %0d expected 0", c); end
        start(1'b0, 1'b1, 32'd9, 32'd2);
        watch(40, f, c, r, e);
        tests_run++;
        if (f !== 32) begin tests_failed++; $display("FAIL midrst_div_latency: got %0d expected 32", f); end
        tests_run++;
        if (r !== 32'd4) begin tests_failed++; $display("FAIL midrst_div_result: got %h expected 00000004", r); end
    endtask

    task automatic test_simultaneous();
        int f, c; logic [31:0] r; logic e;
        @(negedge clock);
        start(1'b1, 1'b1, 32'd6, 32'd3);
        watch(40, f, c, r, e);
        tests_run++;
        if (r !== 32'd18) begin tests_failed++; $display("FAIL simul_result: got %h expected 00000012", r); end
        tests_run++;
        if (f !== 32) begin tests_failed++; $display("FAIL simul_latency: got %0d expected 32", f); end
    endtask

    initial begin
        reset             = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        test_reset();
        test_mult_neg();
        test_mult_ovf();
        test_div();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
